// File: rtl/rmw_long_latency_tbl_sched.sv
// Table RAM scheduler: queues cache reads and writes, issues one RAM op per cycle, and returns tagged read data.
// Optional macro RMW_LONG_LATENCY_TBL_SCHED_FWD_EN: serve RAW-hazard reads from the write queue instead of stalling.
module rmw_long_latency_tbl_sched #(
  parameter int unsigned ID_W  = 8,
  parameter int unsigned W     = 32,
  parameter int unsigned TAG_W = 3,
  parameter int unsigned LAT   = 4,
  parameter int unsigned RQ_N  = 4,
  parameter int unsigned WQ_N  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tbl_rd_r,
  input  logic [ID_W-1:0]  tbl_rd_id_r,
  input  logic [TAG_W-1:0] tbl_rd_itag_r,
  input  logic             tbl_wr_r,
  input  logic [ID_W-1:0]  tbl_wr_id_r,
  input  logic [W-1:0]     tbl_wr_word_r,
  output logic             tbl_rd_word_vld_r,
  output logic [W-1:0]     tbl_rd_word_r,
  output logic [TAG_W-1:0] tbl_rd_ctag_r,
  output logic             ram_en,
  output logic             ram_wen,
  output logic [ID_W-1:0]  ram_addr,
  output logic [W-1:0]     ram_wdata,
  input  logic [W-1:0]     ram_rdata,
  output logic             sched_afull_w,
  output logic             err_ovf_r
);
  localparam int unsigned RQ_AW = $clog2(RQ_N);
  localparam int unsigned RQ_CW = $clog2(RQ_N + 1);
  localparam int unsigned WQ_AW = $clog2(WQ_N);
  localparam int unsigned WQ_CW = $clog2(WQ_N + 1);
  localparam logic [RQ_CW-1:0] RQ_FULL = RQ_CW'(RQ_N);
  localparam logic [RQ_CW-1:0] RQ_THR  = RQ_CW'(RQ_N - 1);
  localparam logic [WQ_CW-1:0] WQ_FULL = WQ_CW'(WQ_N);
  localparam logic [WQ_CW-1:0] WQ_THR  = WQ_CW'(WQ_N - 1);

  function automatic int unsigned wrap(input int unsigned s, input int unsigned n);
    return (s >= n) ? s - n : s;
  endfunction

  logic [ID_W-1:0]  rq_id_q   [RQ_N];
  logic [ID_W-1:0]  rq_id_d   [RQ_N];
  logic [TAG_W-1:0] rq_tag_q  [RQ_N];
  logic [TAG_W-1:0] rq_tag_d  [RQ_N];
  logic [RQ_AW-1:0] rq_head_q, rq_head_d, rq_tail;
  logic [RQ_CW-1:0] rq_cnt_q, rq_cnt_d;

  logic [ID_W-1:0]  wq_id_q   [WQ_N];
  logic [ID_W-1:0]  wq_id_d   [WQ_N];
  logic [W-1:0]     wq_word_q [WQ_N];
  logic [W-1:0]     wq_word_d [WQ_N];
  logic [WQ_AW-1:0] wq_head_q, wq_head_d, wq_tail;
  logic [WQ_CW-1:0] wq_cnt_q, wq_cnt_d;

  logic             ram_en_q, ram_en_d, ram_wen_q, ram_wen_d;
  logic [ID_W-1:0]  ram_addr_q, ram_addr_d;
  logic [W-1:0]     ram_wdata_q, ram_wdata_d;

  logic [LAT:0]     pipe_vld_q, pipe_vld_d;
  logic [TAG_W-1:0] pipe_tag_q [LAT+1];
  logic [TAG_W-1:0] pipe_tag_d [LAT+1];
`ifdef RMW_LONG_LATENCY_TBL_SCHED_FWD_EN
  logic [LAT:0]     pipe_fwd_q, pipe_fwd_d;
  logic [W-1:0]     pipe_data_q [LAT+1];
  logic [W-1:0]     pipe_data_d [LAT+1];
  logic [W-1:0]     fwd_word;
`endif

  logic             rd_vld_q, rd_vld_d;
  logic [W-1:0]     rd_word_q, rd_word_d;
  logic [TAG_W-1:0] rd_ctag_q, rd_ctag_d;
  logic             err_ovf_q, err_ovf_d;

  logic             rq_empty, rq_full, wq_empty, wq_full, wq_thr;
  logic [ID_W-1:0]  rq_head_id;
  logic             haz_wq, haz_in, stall, fwd;
  logic             gnt_r, gnt_w, rq_pop, wq_pop, rq_push, wq_push;

  assign rq_empty   = (rq_cnt_q == '0);
  assign rq_full    = (rq_cnt_q == RQ_FULL);
  assign wq_empty   = (wq_cnt_q == '0);
  assign wq_full    = (wq_cnt_q == WQ_FULL);
  assign wq_thr     = (wq_cnt_q >= WQ_THR);
  assign rq_head_id = rq_id_q[rq_head_q];
  assign rq_tail    = RQ_AW'(wrap(32'(rq_head_q) + 32'(rq_cnt_q), RQ_N));
  assign wq_tail    = WQ_AW'(wrap(32'(wq_head_q) + 32'(wq_cnt_q), WQ_N));

  // Scan queued writes oldest to youngest so the last match is the youngest one.
  always_comb begin
    haz_wq = 1'b0;
`ifdef RMW_LONG_LATENCY_TBL_SCHED_FWD_EN
    fwd_word = '0;
`endif
    for (int unsigned i = 0; i < WQ_N; i++) begin
      if ((WQ_CW'(i) < wq_cnt_q) &&
          (wq_id_q[WQ_AW'(wrap(32'(wq_head_q) + i, WQ_N))] == rq_head_id)) begin
        haz_wq = !rq_empty;
`ifdef RMW_LONG_LATENCY_TBL_SCHED_FWD_EN
        fwd_word = wq_word_q[WQ_AW'(wrap(32'(wq_head_q) + i, WQ_N))];
`endif
      end
    end
    haz_in = !rq_empty && tbl_wr_r && (tbl_wr_id_r == rq_head_id);
  end

  always_comb begin
    gnt_r = 1'b0;
    gnt_w = 1'b0;
`ifdef RMW_LONG_LATENCY_TBL_SCHED_FWD_EN
    // A write arriving this cycle is younger than the head read, so only queued matches forward.
    fwd   = haz_wq;
    stall = haz_in && !haz_wq;
`else
    fwd   = 1'b0;
    stall = haz_wq || haz_in;
`endif
    if (fwd || stall) begin
      gnt_w = !wq_empty;
    end else if (wq_thr) begin
      gnt_w = 1'b1;
    end else if (!rq_empty) begin
      gnt_r = 1'b1;
    end else if (!wq_empty) begin
      gnt_w = 1'b1;
    end
  end

  always_comb begin
    rq_pop    = gnt_r || fwd;
    wq_pop    = gnt_w;
    rq_push   = tbl_rd_r && (!rq_full || rq_pop);
    wq_push   = tbl_wr_r && (!wq_full || wq_pop);
    err_ovf_d = err_ovf_q || (tbl_rd_r && !rq_push) || (tbl_wr_r && !wq_push);

    rq_id_d  = rq_id_q;
    rq_tag_d = rq_tag_q;
    if (rq_push) begin
      rq_id_d[rq_tail]  = tbl_rd_id_r;
      rq_tag_d[rq_tail] = tbl_rd_itag_r;
    end
    rq_head_d = rq_pop ? RQ_AW'(wrap(32'(rq_head_q) + 1, RQ_N)) : rq_head_q;
    rq_cnt_d  = rq_cnt_q + RQ_CW'(rq_push) - RQ_CW'(rq_pop);

    wq_id_d   = wq_id_q;
    wq_word_d = wq_word_q;
    if (wq_push) begin
      wq_id_d[wq_tail]   = tbl_wr_id_r;
      wq_word_d[wq_tail] = tbl_wr_word_r;
    end
    wq_head_d = wq_pop ? WQ_AW'(wrap(32'(wq_head_q) + 1, WQ_N)) : wq_head_q;
    wq_cnt_d  = wq_cnt_q + WQ_CW'(wq_push) - WQ_CW'(wq_pop);

    ram_en_d    = gnt_r || gnt_w;
    ram_wen_d   = gnt_w;
    ram_addr_d  = gnt_w ? wq_id_q[wq_head_q] : rq_head_id;
    ram_wdata_d = wq_word_q[wq_head_q];

    // Stage 0 lines up with the RAM op; stage LAT lines up with ram_rdata.
    pipe_vld_d    = {pipe_vld_q[LAT-1:0], gnt_r || fwd};
    pipe_tag_d[0] = rq_tag_q[rq_head_q];
    for (int unsigned k = 1; k <= LAT; k++) begin
      pipe_tag_d[k] = pipe_tag_q[k-1];
    end
`ifdef RMW_LONG_LATENCY_TBL_SCHED_FWD_EN
    pipe_fwd_d     = {pipe_fwd_q[LAT-1:0], fwd};
    pipe_data_d[0] = fwd_word;
    for (int unsigned k = 1; k <= LAT; k++) begin
      pipe_data_d[k] = pipe_data_q[k-1];
    end
`endif

    rd_vld_d  = pipe_vld_q[LAT];
    rd_word_d = rd_word_q;
    rd_ctag_d = rd_ctag_q;
    if (pipe_vld_q[LAT]) begin
`ifdef RMW_LONG_LATENCY_TBL_SCHED_FWD_EN
      rd_word_d = pipe_fwd_q[LAT] ? pipe_data_q[LAT] : ram_rdata;
`else
      rd_word_d = ram_rdata;
`endif
      rd_ctag_d = pipe_tag_q[LAT];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rq_head_q  <= '0;
      rq_cnt_q   <= '0;
      wq_head_q  <= '0;
      wq_cnt_q   <= '0;
      ram_en_q   <= 1'b0;
      ram_wen_q  <= 1'b0;
      pipe_vld_q <= '0;
      rd_vld_q   <= 1'b0;
      err_ovf_q  <= 1'b0;
`ifdef RMW_LONG_LATENCY_TBL_SCHED_FWD_EN
      pipe_fwd_q <= '0;
`endif
    end else begin
      rq_head_q  <= rq_head_d;
      rq_cnt_q   <= rq_cnt_d;
      wq_head_q  <= wq_head_d;
      wq_cnt_q   <= wq_cnt_d;
      ram_en_q   <= ram_en_d;
      ram_wen_q  <= ram_wen_d;
      pipe_vld_q <= pipe_vld_d;
      rd_vld_q   <= rd_vld_d;
      err_ovf_q  <= err_ovf_d;
`ifdef RMW_LONG_LATENCY_TBL_SCHED_FWD_EN
      pipe_fwd_q <= pipe_fwd_d;
`endif
    end
  end

  // Payload registers carry no reset; their valids qualify them.
  always_ff @(posedge clk) begin
    rq_id_q     <= rq_id_d;
    rq_tag_q    <= rq_tag_d;
    wq_id_q     <= wq_id_d;
    wq_word_q   <= wq_word_d;
    ram_addr_q  <= ram_addr_d;
    ram_wdata_q <= ram_wdata_d;
    pipe_tag_q  <= pipe_tag_d;
    rd_word_q   <= rd_word_d;
    rd_ctag_q   <= rd_ctag_d;
`ifdef RMW_LONG_LATENCY_TBL_SCHED_FWD_EN
    pipe_data_q <= pipe_data_d;
`endif
  end

  assign ram_en            = ram_en_q;
  assign ram_wen           = ram_wen_q;
  assign ram_addr          = ram_addr_q;
  assign ram_wdata         = ram_wdata_q;
  assign tbl_rd_word_vld_r = rd_vld_q;
  assign tbl_rd_word_r     = rd_word_q;
  assign tbl_rd_ctag_r     = rd_ctag_q;
  assign err_ovf_r         = err_ovf_q;
  assign sched_afull_w     = (rq_cnt_q >= RQ_THR) || (wq_cnt_q >= WQ_THR);

endmodule

// File: tb/tb_rmw_long_latency_tbl_sched.sv
// Scoreboard bench for rmw_long_latency_tbl_sched with a behavioural fixed-latency table RAM.
module tb_rmw_long_latency_tbl_sched;
  localparam int unsigned ID_W  = 8;
  localparam int unsigned W     = 32;
  localparam int unsigned TAG_W = 3;
  localparam int unsigned LAT   = 4;
  localparam int unsigned RQ_N  = 4;
  localparam int unsigned WQ_N  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tbl_rd_r = 1'b0;
  logic [ID_W-1:0]  tbl_rd_id_r = '0;
  logic [TAG_W-1:0] tbl_rd_itag_r = '0;
  logic             tbl_wr_r = 1'b0;
  logic [ID_W-1:0]  tbl_wr_id_r = '0;
  logic [W-1:0]     tbl_wr_word_r = '0;
  logic             tbl_rd_word_vld_r;
  logic [W-1:0]     tbl_rd_word_r;
  logic [TAG_W-1:0] tbl_rd_ctag_r;
  logic             ram_en, ram_wen;
  logic [ID_W-1:0]  ram_addr;
  logic [W-1:0]     ram_wdata, ram_rdata;
  logic             sched_afull_w, err_ovf_r;

  rmw_long_latency_tbl_sched #(
    .ID_W (ID_W), .W (W), .TAG_W (TAG_W), .LAT (LAT), .RQ_N (RQ_N), .WQ_N (WQ_N)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .tbl_rd_r          (tbl_rd_r),
    .tbl_rd_id_r       (tbl_rd_id_r),
    .tbl_rd_itag_r     (tbl_rd_itag_r),
    .tbl_wr_r          (tbl_wr_r),
    .tbl_wr_id_r       (tbl_wr_id_r),
    .tbl_wr_word_r     (tbl_wr_word_r),
    .tbl_rd_word_vld_r (tbl_rd_word_vld_r),
    .tbl_rd_word_r     (tbl_rd_word_r),
    .tbl_rd_ctag_r     (tbl_rd_ctag_r),
    .ram_en            (ram_en),
    .ram_wen           (ram_wen),
    .ram_addr          (ram_addr),
    .ram_wdata         (ram_wdata),
    .ram_rdata         (ram_rdata),
    .sched_afull_w     (sched_afull_w),
    .err_ovf_r         (err_ovf_r)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural RAM: unwritten locations hold a fixed pattern, data appears LAT cycles after a read.
  function automatic logic [W-1:0] init_val(input logic [ID_W-1:0] a);
    return (a == 8'h05) ? 32'hDEAD_BEEF : {24'hA5A5A5, a};
  endfunction

  logic [W-1:0]     mem [256];
  logic [255:0]     written;
  logic [W-1:0]     dly_q [LAT];
  logic [LAT-1:0]   dvld_q;

  always @(posedge clk) begin
    if (rst && cyc < 4) begin
      written <= '0;
    end else if (ram_en && ram_wen) begin
      mem[ram_addr]     <= ram_wdata;
      written[ram_addr] <= 1'b1;
    end
    dly_q[0]  <= written[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
    dvld_q[0] <= ram_en && !ram_wen;
    for (int k = 1; k < LAT; k++) begin
      dly_q[k]  <= dly_q[k-1];
      dvld_q[k] <= dvld_q[k-1];
    end
  end
  assign ram_rdata = dvld_q[LAT-1] ? dly_q[LAT-1] : 32'hBAD0_BAD0;

  typedef struct {
    logic [W-1:0]     word;
    logic [TAG_W-1:0] tag;
    int               cyc;
    string            name;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   vld_seen = 0;

  always @(negedge clk) begin
    if (tbl_rd_word_vld_r === 1'b1) begin
      vld_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_return word=%0h tag=%0d cycle=%0d, no return expected",
                 tbl_rd_word_r, tbl_rd_ctag_r, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk({mon_e.name, "_word"}, 64'(tbl_rd_word_r), 64'(mon_e.word));
        chk({mon_e.name, "_tag"}, 64'(tbl_rd_ctag_r), 64'(mon_e.tag));
        if (mon_e.cyc >= 0) chk({mon_e.name, "_cycle"}, 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  logic [8:0] op_q[$];
  always @(negedge clk) begin
    if (ram_en === 1'b1) op_q.push_back({ram_wen, ram_addr});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tbl_rd_r = 1'b0;
    tbl_wr_r = 1'b0;
  endtask

  task automatic set_rd(input logic [ID_W-1:0] id, input logic [TAG_W-1:0] tag);
    tbl_rd_r      = 1'b1;
    tbl_rd_id_r   = id;
    tbl_rd_itag_r = tag;
  endtask

  task automatic set_wr(input logic [ID_W-1:0] id, input logic [W-1:0] word);
    tbl_wr_r      = 1'b1;
    tbl_wr_id_r   = id;
    tbl_wr_word_r = word;
  endtask

  task automatic expect_rd(input string name, input logic [W-1:0] word,
                           input logic [TAG_W-1:0] tag, input int c);
    exp_t e;
    e.word = word;
    e.tag  = tag;
    e.cyc  = c;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    chk({name, "_pending_returns"}, 64'(exp_q.size()), 64'd0);
    repeat (3) tick();
  endtask

  task automatic chk_ops(input string name, input logic [8:0] e[12], input int n);
    chk({name, "_op_count"}, 64'(op_q.size()), 64'(n));
    for (int i = 0; i < n && i < op_q.size(); i++) begin
      chk($sformatf("%s_op%0d", name, i), 64'(op_q[i]), 64'(e[i]));
    end
  endtask

  logic [8:0] eops[12];
  int         k0;
  int         seen0;

  initial begin
    #100000;
    $display("FAIL global_timeout reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    repeat (3) tick();
    chk("rst_vld", 64'(tbl_rd_word_vld_r), 64'd0);
    chk("rst_ovf", 64'(err_ovf_r), 64'd0);
    chk("rst_ram_en", 64'(ram_en), 64'd0);
    chk("rst_ram_wen", 64'(ram_wen), 64'd0);
    chk("rst_afull", 64'(sched_afull_w), 64'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Single read: RAM at E+2, return at E+LAT+3.
    op_q.delete();
    k0 = cyc;
    set_rd(8'h05, 3'd2);
    expect_rd("t1_single", 32'hDEAD_BEEF, 3'd2, k0 + LAT + 3);
    tick();
    idle();
    tick();
    chk("t1_ram_en", 64'(ram_en), 64'd1);
    chk("t1_ram_wen", 64'(ram_wen), 64'd0);
    chk("t1_ram_addr", 64'(ram_addr), 64'h05);
    wait_drain("t1");
    eops[0] = 9'h005;
    chk_ops("t1", eops, 1);

    // Same-cycle write and read to one id: write is older and goes first.
    op_q.delete();
    k0 = cyc;
    set_wr(8'h07, 32'h11);
    set_rd(8'h07, 3'd3);
    expect_rd("t2_raw", 32'h11, 3'd3, k0 + LAT + 4);
    tick();
    idle();
    wait_drain("t2");
    eops[0] = 9'h107;
    eops[1] = 9'h007;
    chk_ops("t2", eops, 2);

    // Head read held by a stream of matching writes; fifth read overflows.
    op_q.delete();
    for (int i = 0; i < 6; i++) begin
      if (i == 2) chk("t3_afull_2rd", 64'(sched_afull_w), 64'd0);
      if (i == 3) chk("t3_afull_3rd", 64'(sched_afull_w), 64'd1);
      if (i == 4) chk("t3_ovf_before", 64'(err_ovf_r), 64'd0);
      if (i == 5) chk("t3_ovf_after", 64'(err_ovf_r), 64'd1);
      set_wr(8'h20, 32'hC0DE_0000 + 32'(i));
      if (i < 5) set_rd(8'h20 + 8'(i), 3'(i));
      else tbl_rd_r = 1'b0;
      tick();
    end
    idle();
    expect_rd("t3_r0", 32'hC0DE_0005, 3'd0, -1);
    expect_rd("t3_r1", 32'hA5A5_A521, 3'd1, -1);
    expect_rd("t3_r2", 32'hA5A5_A522, 3'd2, -1);
    expect_rd("t3_r3", 32'hA5A5_A523, 3'd3, -1);
    wait_drain("t3");
    for (int i = 0; i < 6; i++) eops[i] = 9'h120;
    eops[6] = 9'h020;
    eops[7] = 9'h021;
    eops[8] = 9'h022;
    eops[9] = 9'h023;
    chk_ops("t3", eops, 10);

    // Alternating single reads and writes to distinct ids.
    op_q.delete();
    k0 = cyc;
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i % 2 == 0) begin
        set_rd(8'h30 + 8'(i / 2), 3'(5 + i / 2));
        expect_rd($sformatf("t4_r%0d", i / 2), 32'hA5A5_A530 + 32'(i / 2), 3'(5 + i / 2),
                  k0 + i + LAT + 3);
      end else begin
        set_wr(8'h40 + 8'(i / 2), 32'h4000_0000 + 32'(i));
      end
      tick();
    end
    idle();
    wait_drain("t4");
    eops[0] = 9'h030; eops[1] = 9'h140; eops[2] = 9'h031;
    eops[3] = 9'h141; eops[4] = 9'h032; eops[5] = 9'h142;
    chk_ops("t4", eops, 6);

    // Write queue at threshold takes priority over queued non-hazard reads.
    op_q.delete();
    k0 = cyc;
    for (int i = 0; i < 4; i++) begin
      idle();
      if (i == 3) chk("t6_afull_wq3", 64'(sched_afull_w), 64'd1);
      if (i < 3) set_rd(8'h50 + 8'(i), 3'(i));
      set_wr(8'h60 + 8'(i), 32'h6000_0000 + 32'(i));
      tick();
    end
    idle();
    expect_rd("t6_r0", 32'hA5A5_A550, 3'd0, k0 + 7);
    expect_rd("t6_r1", 32'hA5A5_A551, 3'd1, k0 + 8);
    expect_rd("t6_r2", 32'hA5A5_A552, 3'd2, k0 + 11);
    wait_drain("t6");
    eops[0] = 9'h050; eops[1] = 9'h051; eops[2] = 9'h160; eops[3] = 9'h161;
    eops[4] = 9'h052; eops[5] = 9'h162; eops[6] = 9'h163;
    chk_ops("t6", eops, 7);
    chk("ovf_sticky", 64'(err_ovf_r), 64'd1);

    // Reset with two reads in flight: no returns afterwards, state cleared.
    op_q.delete();
    set_rd(8'h70, 3'd1);
    tick();
    set_rd(8'h71, 3'd2);
    tick();
    idle();
    tick();
    chk("t5_inflight_en", 64'(ram_en), 64'd1);
    chk("t5_inflight_addr", 64'(ram_addr), 64'h71);
    seen0 = vld_seen;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_ovf_cleared", 64'(err_ovf_r), 64'd0);
    chk("t5_afull", 64'(sched_afull_w), 64'd0);
    chk("t5_ram_en", 64'(ram_en), 64'd0);
    repeat (LAT + 6) tick();
    chk("t5_no_stale_return", 64'(vld_seen), 64'(seen0));
    k0 = cyc;
    set_rd(8'h05, 3'd6);
    expect_rd("t5_post_rst", 32'hDEAD_BEEF, 3'd6, k0 + LAT + 3);
    tick();
    idle();
    wait_drain("t5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
